onehot_decoder_pipe: RTL
========================

Name: onehot_decoder_pipe

Overview:
- Parametrised, pipelined successor to the team's 3-to-8 combinational decoder.
- Decodes an IDX_W-bit index into a 2**IDX_W-bit vector. Two modes: one-hot for register-file write enables, thermometer for byte/lane masks.
- Optional masking of index 0 (x0 hard-wired zero).
- Registered output behind a valid/ready handshake with a 2-entry skid buffer, so it sits between decode and register-file/FPU write-back stages without combinational ready paths.

Parameters:
- IDX_W, 3, index width; output width OUT_W = 2**IDX_W (1 <= IDX_W <= 6).
- ZERO_MASK, 0, when 1 output bit 0 is never set in either mode (x0 protection).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_valid  in  1  input request valid.
- o_ready  out  1  block can accept input; registered, depends only on buffer state.
- i_index  in  IDX_W  index to decode.
- i_en  in  1  decode enable; 0 forces an all-zero result.
- i_mode  in  1  0 = one-hot, 1 = thermometer.
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts result.
- o_dec  out  OUT_W  decoded vector.

Behaviour:
- Reset (async, active-low): o_valid=0, o_dec=0, o_ready=1, buffer count=0. Asserting reset mid-operation discards all buffered results immediately; no result is emitted after release until a new push.
- Push = i_valid & o_ready at a rising edge. Pop = o_valid & i_ready at a rising edge.
- Decode function, evaluated on the input at push time:
  - i_en=0: result = 0.
  - Mode 0: bit i_index = 1, all others 0.
  - Mode 1: bits [i_index:0] = 1, bits above = 0. Index OUT_W-1 gives all ones.
  - ZERO_MASK=1: bit 0 of the result forced to 0 after the mode decode. One-hot index 0 therefore gives all zeros; thermometer index 0 gives zero.
- Storage: main register (drives o_dec/o_valid) plus skid register. States by count:
  - EMPTY: o_valid=0, o_ready=1, o_dec=0. Push -> ONE; result appears on o_dec the next cycle (latency 1).
  - ONE: o_valid=1, o_ready=1.
    - Push without pop: result goes to skid -> TWO.
    - Pop without push -> EMPTY; o_dec cleared to 0.
    - Push and pop together: main loaded with new result, stays ONE. Sustains 1 result/cycle.
  - TWO: o_valid=1, o_ready=0; pushes impossible.
    - Pop: skid moves to main -> ONE; o_ready=1 the next cycle.
    - No pop: hold.
- Ordering strictly FIFO. No result is dropped or duplicated.
- o_dec and o_valid stay stable while o_valid=1 and i_ready=0.
- i_valid may drop without a push; no internal state changes.
- i_index, i_mode and i_en are only sampled on push.
- No X propagation: all outputs driven from registers.

Test Plan:
1. Reset held low with i_valid=1 -> o_valid=0, o_dec=8'h00, o_ready=1. Release; push index 5, mode 0, en 1, i_ready=1 -> next cycle o_valid=1, o_dec=8'b0010_0000.
2. Streaming, i_ready=1: push indices 0..7 in mode 0 on consecutive cycles (ZERO_MASK=0) -> o_dec 8'h01,02,04,...,80 on consecutive cycles, o_ready stays 1. Repeat in mode 1 -> 8'h01,03,07,0F,1F,3F,7F,FF.
3. Backpressure: i_ready=0; push index 2 then index 6 -> o_ready=0 after the second push, o_dec holds 8'h04. Raise i_ready -> o_dec 8'h04 then 8'h40, then o_valid=0 with o_dec=8'h00. o_ready returns to 1 one cycle after the first pop.
4. Masking: ZERO_MASK=1, push index 0 mode 0 -> o_dec=8'h00 with o_valid=1. Push index 3 mode 1 -> 8'h0E. Push index 7 with en=0 -> 8'h00.
5. Mid-operation reset: buffer in TWO state, assert i_rst_n=0 asynchronously (between edges) -> o_valid and o_dec zero immediately, o_ready=1. After release, no stale result appears.
6. Width: IDX_W=5, push index 31 mode 0 -> o_dec bit 31 only. Push index 16 mode 1 -> 32'h0001_FFFF.

Source files
------------

// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - pipelined one-hot/thermometer index decoder with 2-entry skid buffer
module onehot_decoder_pipe #(
    parameter  int IDX_W     = 3,
    parameter  int ZERO_MASK = 0,
    localparam int OUT_W     = 1 << IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_en,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_dec
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] main_d;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] skid_d;
    logic             valid_q;
    logic             valid_d;
    logic             ready_q;
    logic             ready_d;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] dec_in;

    // Mode decode first, then the x0 mask, so index 0 never sets bit 0 in either mode.
    function automatic logic [OUT_W-1:0] decode(
        input logic [IDX_W-1:0] idx,
        input logic             en,
        input logic             mode
    );
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (mode) begin
                r[i] = (IDX_W'(i) <= idx);
            end else begin
                r[i] = (IDX_W'(i) == idx);
            end
        end
        if (!en) begin
            r = '0;
        end
        if (ZERO_MASK != 0) begin
            r[0] = 1'b0;
        end
        return r;
    endfunction

    assign push   = i_valid & ready_q;
    assign pop    = valid_q & i_ready;
    assign dec_in = decode(i_index, i_en, i_mode);

    // State and data registers; reset discards anything buffered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Next buffer state: main register always holds the oldest result, skid the younger.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_d  = dec_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = dec_in;
                end else if (push) begin
                    skid_d  = dec_in;
                    state_d = ST_TWO;
                end else if (pop) begin
                    main_d  = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
            end
        endcase
    end

    // Handshake flags are precomputed from the next state so they leave straight from flops.
    always_comb begin
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_dec   = main_q;

endmodule
